// File: rtl/icache_2way_pkg.sv
// icache_2way shared definitions: widths, read-port burst types,
// controller states and the captured request bundle.
package icache_2way_pkg;

    localparam int ICACHE_INDEX_WD  = 8;
    localparam int ICACHE_TAG_WD    = 20;
    localparam int ICACHE_OFFSET_WD = 4;
    localparam int NSET             = 256;
    localparam int NWORD            = 4;

    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REPLACE,
        S_REFILL
    } cache_state_e;

    typedef struct packed {
        logic [ICACHE_INDEX_WD-1:0]  index;
        logic [ICACHE_TAG_WD-1:0]    ptag;
        logic [ICACHE_OFFSET_WD-1:0] offset;
        logic                        uncached;
    } req_buf_t;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB.
    function automatic logic [ICACHE_TAG_WD-1:0] phys_tag(
        input logic [ICACHE_TAG_WD-1:0] t
    );
        return (t[19:18] == 2'b10) ? {3'b000, t[16:0]} : t;
    endfunction

endpackage

// File: rtl/icache_way_ram.sv
// One cache way: tag array plus four word banks, synchronous read
// port and an independent write port with per-bank enables.
module icache_way_ram
    import icache_2way_pkg::*;
(
    input  logic                       clk,
    input  logic                       ren,
    input  logic [ICACHE_INDEX_WD-1:0] raddr,
    input  logic [ICACHE_INDEX_WD-1:0] waddr,
    input  logic                       tag_we,
    input  logic [ICACHE_TAG_WD-1:0]   wtag,
    input  logic [NWORD-1:0]           bank_we,
    input  logic [31:0]                wdata,
    output logic [ICACHE_TAG_WD-1:0]   rtag,
    output logic [NWORD-1:0][31:0]     rline
);

    logic [ICACHE_TAG_WD-1:0] tag_mem [NSET];
    logic [31:0]              bank    [NWORD][NSET];

    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[waddr] <= wtag;
        if (ren)    rtag <= tag_mem[raddr];
        for (int b = 0; b < NWORD; b++) begin
            if (bank_we[b]) bank[b][waddr] <= wdata;
            if (ren)        rline[b] <= bank[b][raddr];
        end
    end

endmodule

// File: rtl/icache_2way.sv
// 2-way read-only instruction cache with an sram-like fetch port
// and a single-outstanding burst read port toward the bus bridge.
module icache_2way
    import icache_2way_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic        op,
    input  logic [7:0]  index,
    input  logic [19:0] tag,
    input  logic [3:0]  offset,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    cache_state_e state, state_nx;
    req_buf_t     rb;

    logic [NSET-1:0]          vld [2];
    logic [NSET-1:0]          lru;
    logic                     victim;
    logic [1:0]               cnt;
    logic [31:0]              wbuf;
    logic [ICACHE_TAG_WD-1:0] rtag  [2];
    logic [NWORD-1:0][31:0]   rline [2];

    logic hit0, hit1, hit, hit_way;
    logic accept, beat, last, crit;

    logic unused_ok;
    assign unused_ok = ^{op, wstrb, wdata};

    assign hit0 = vld[0][rb.index] && rtag[0] == rb.ptag && !rb.uncached;
    assign hit1 = vld[1][rb.index] && rtag[1] == rb.ptag && !rb.uncached;
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;
    assign accept  = valid && addr_ok;
    assign beat    = state == S_REFILL && ret_valid;
    assign last    = beat && ret_last;
    assign crit    = cnt == rb.offset[3:2];

    for (genvar w = 0; w < 2; w++) begin : g_way
        logic sel;
        assign sel = victim == w[0] && !rb.uncached;
        icache_way_ram u_ram (
            .clk     (clk),
            .ren     (accept),
            .raddr   (index),
            .waddr   (rb.index),
            .tag_we  (last && sel),
            .wtag    (rb.ptag),
            .bank_we ((beat && sel) ? (4'b0001 << cnt) : 4'b0000),
            .wdata   (ret_data),
            .rtag    (rtag[w]),
            .rline   (rline[w])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (accept) state_nx = S_LOOKUP;
            S_LOOKUP:  state_nx = !hit   ? S_REPLACE :
                                  accept ? S_LOOKUP  : S_IDLE;
            S_REPLACE: if (rd_rdy) state_nx = S_REFILL;
            S_REFILL:  if (last)   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        addr_ok = 1'b0;
        data_ok = 1'b0;
        rdata   = '0;
        rd_req  = 1'b0;
        rd_type = '0;
        rd_addr = '0;
        unique case (state)
            S_IDLE: addr_ok = resetn;
            S_LOOKUP: if (hit) begin
                addr_ok = resetn;
                data_ok = 1'b1;
                rdata   = rline[hit_way][rb.offset[3:2]];
            end
            S_REPLACE: begin
                rd_req  = 1'b1;
                rd_type = rb.uncached ? RD_TYPE_WORD : RD_TYPE_LINE;
                rd_addr = {rb.ptag, rb.index,
                           rb.uncached ? rb.offset : 4'b0000};
            end
            S_REFILL: if (last) begin
                data_ok = 1'b1;
                rdata   = (rb.uncached || crit) ? ret_data : wbuf;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rb     <= '0;
            victim <= 1'b0;
            cnt    <= '0;
            wbuf   <= '0;
        end else begin
            if (accept) begin
                rb.index    <= index;
                rb.ptag     <= phys_tag(tag);
                rb.offset   <= offset;
                rb.uncached <= tag[19:17] == 3'b101;
            end
            if (state == S_LOOKUP && !hit)
                victim <= !vld[0][rb.index] ? 1'b0 :
                          !vld[1][rb.index] ? 1'b1 : lru[rb.index];
            if (state == S_REPLACE) cnt <= '0;
            else if (beat)          cnt <= cnt + 2'd1;
            if (beat && crit) wbuf <= ret_data;
        end
    end

    // lru[i] names the way to evict next once both ways are valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld[0] <= '0;
            vld[1] <= '0;
            lru    <= '0;
        end else begin
            if (state == S_LOOKUP && hit) lru[rb.index] <= !hit_way;
            if (last && !rb.uncached) begin
                vld[victim][rb.index] <= 1'b1;
                lru[rb.index]         <= !victim;
            end
        end
    end

endmodule

// File: tb/tb_icache_2way.sv
// Randomized bench for icache_2way: transaction-level cache model,
// behavioural memory responder and directed scenarios.
module tb_icache_2way;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        op = 1'b0;
    logic [7:0]  index = '0;
    logic [19:0] tag = '0;
    logic [3:0]  offset = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic        addr_ok, data_ok, rd_req;
    logic [31:0] rdata, rd_addr;
    logic [2:0]  rd_type;
    logic        rd_rdy = 1'b0;
    logic        ret_valid = 1'b0;
    logic        ret_last = 1'b0;
    logic [31:0] ret_data = '0;

    icache_2way dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op),
        .index(index), .tag(tag), .offset(offset),
        .wstrb(wstrb), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid),
        .ret_last(ret_last), .ret_data(ret_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 lookup-miss, 2 awaiting read grant, 3 refilling
    logic [31:0] reqs [$];
    bit [19:0]   mtag [2][256];
    bit          mval [2][256];
    bit          mmru [256];
    int          ph = 0;
    bit          hit_due = 0;
    logic [31:0] hit_data, m_data, m_addr;
    logic [2:0]  m_type;
    logic [7:0]  m_idx;
    logic [19:0] m_ptag;
    bit          m_unc, m_way;

    bit          rs_busy = 0;
    logic [31:0] rs_addr;
    int          rs_beats, rs_n;
    int          bp_hold = 0;
    int          stray_cnt = 0;
    int          rst_cnt = 0;
    bit          rst_at2 = 0;
    bit          gap_en = 0;

    int          rd_hs = 0;
    int          req_cycles = 0;
    logic [31:0] last_rdata, last_rd_addr;
    logic [2:0]  last_rd_type;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {16'hC0DE ^ a[31:16], a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic accept_req(input logic [31:0] a);
        logic [31:0] pa;
        logic [7:0]  idx;
        bit          unc;
        int          hw;
        unc = a[31:29] == 3'b101;
        pa  = (a[31:30] == 2'b10) ? (a & 32'h1fff_ffff) : a;
        idx = a[11:4];
        hw  = -1;
        for (int w = 0; w < 2; w++)
            if (hw < 0 && mval[w][idx] && mtag[w][idx] == pa[31:12] && !unc)
                hw = w;
        if (hw >= 0) begin
            hit_due  = 1;
            hit_data = memword({pa[31:2], 2'b00});
            mmru[idx] = hw[0];
        end else begin
            ph     = 1;
            m_idx  = idx;
            m_ptag = pa[31:12];
            m_unc  = unc;
            m_data = memword({pa[31:2], 2'b00});
            m_addr = unc ? pa : {pa[31:4], 4'b0000};
            m_type = unc ? 3'b010 : 3'b100;
            m_way  = !mval[0][idx] ? 1'b0 :
                     !mval[1][idx] ? 1'b1 : !mmru[idx];
        end
    endtask

    task automatic check_cycle();
        bit          exp_dok;
        logic [31:0] exp_rd;
        if (!resetn) begin
            chk("rst_addr_ok", {31'd0, addr_ok}, 0);
            chk("rst_data_ok", {31'd0, data_ok}, 0);
            chk("rst_rd_req", {31'd0, rd_req}, 0);
            chk("rst_rd_type", {29'd0, rd_type}, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_rdata", rdata, 0);
            return;
        end
        exp_dok = 0;
        exp_rd  = '0;
        if (hit_due) begin
            exp_dok = 1;
            exp_rd  = hit_data;
        end else if (ph == 3 && ret_valid && ret_last) begin
            exp_dok = 1;
            exp_rd  = m_data;
        end
        chk("data_ok", {31'd0, data_ok}, {31'd0, exp_dok});
        if (exp_dok) chk("rdata", rdata, exp_rd);
        if (data_ok === 1'b1) last_rdata = rdata;
        chk("addr_ok", {31'd0, addr_ok}, {31'd0, ph == 0});
        chk("rd_req", {31'd0, rd_req}, {31'd0, ph == 2});
        if (ph == 2) begin
            chk("rd_addr", rd_addr, m_addr);
            chk("rd_type", {29'd0, rd_type}, {29'd0, m_type});
            req_cycles++;
        end
        if (rs_busy && ret_valid) begin
            rs_beats++;
            if (ret_last) rs_busy = 0;
        end
        if (!rs_busy && rd_req && rd_rdy) begin
            rd_hs++;
            last_rd_addr = rd_addr;
            last_rd_type = rd_type;
            rs_busy  = 1;
            rs_addr  = rd_addr;
            rs_beats = 0;
            rs_n     = (rd_type == 3'b100) ? 4 : 1;
        end
        if (rst_at2 && rs_busy && rs_beats == 2) begin
            rst_cnt = 2;
            rst_at2 = 0;
        end
        hit_due = 0;
        case (ph)
            1: ph = 2;
            2: if (rd_rdy) ph = 3;
            3: if (ret_valid && ret_last) begin
                if (!m_unc) begin
                    mtag[m_way][m_idx] = m_ptag;
                    mval[m_way][m_idx] = 1;
                    mmru[m_idx] = m_way;
                end
                ph = 0;
            end
            default: ;
        endcase
        if (valid && addr_ok) begin
            accept_req({tag, index, offset});
            if (reqs.size() > 0) void'(reqs.pop_front());
        end
    endtask

    task automatic drive_next();
        if (rst_cnt > 0) begin
            resetn = 1'b0;
            rst_cnt--;
            for (int w = 0; w < 2; w++)
                for (int i = 0; i < 256; i++) mval[w][i] = 0;
            ph = 0;
            hit_due = 0;
            rs_busy = 0;
        end else begin
            resetn = 1'b1;
        end
        valid = reqs.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0);
        if (reqs.size() > 0) {tag, index, offset} = reqs[0];
        op    = 1'($urandom);
        wstrb = 4'($urandom);
        wdata = $urandom;
        if (rd_req && bp_hold > 0) begin
            rd_rdy = 1'b0;
            bp_hold--;
        end else begin
            rd_rdy = $urandom_range(0, 2) != 0;
        end
        if (rs_busy) begin
            ret_valid = $urandom_range(0, 3) != 0;
            ret_data  = (rs_n == 4) ? memword(rs_addr + 32'(4 * rs_beats))
                                    : memword(rs_addr);
            ret_last  = ret_valid && rs_beats == rs_n - 1;
        end else if (stray_cnt > 0) begin
            ret_valid = 1'b1;
            ret_last  = 1'b1;
            ret_data  = $urandom;
            stray_cnt--;
        end else begin
            ret_valid = 1'b0;
            ret_last  = 1'b0;
            ret_data  = '0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        drive_next();
    endtask

    function automatic bit idle_all();
        return reqs.size() == 0 && ph == 0 && !hit_due && !rs_busy
               && rst_cnt == 0;
    endfunction

    task automatic run(input int maxc);
        int n = 0;
        while (!idle_all() && n < maxc) begin
            step();
            n++;
        end
        if (!idle_all()) begin
            checks++;
            errors++;
            $display("FAIL timeout: still busy after %0d cycles", n);
            reqs.delete();
        end
    endtask

    logic [19:0] tag_pool [6] = '{20'h00001, 20'h00002, 20'h00003,
                                  20'h80001, 20'hA0002, 20'h00010};
    logic [7:0]  idx_pool [4] = '{8'h23, 8'h24, 8'h00, 8'hFF};

    initial begin
        int hs0;
        rst_cnt = 3;
        repeat (4) step();

        reqs.push_back(32'h0000_1230);
        run(200);
        chk("cold_rd_addr", last_rd_addr, 32'h0000_1230);
        chk("cold_rd_type", {29'd0, last_rd_type}, 32'd4);
        chk("cold_rdata", last_rdata, 32'hC0DE_1230);
        chk("cold_hs", rd_hs, 1);

        hs0 = rd_hs;
        reqs.push_back(32'h0000_1234);
        reqs.push_back(32'h0000_1238);
        run(50);
        chk("b2b_no_req", rd_hs - hs0, 0);
        chk("b2b_rdata", last_rdata, 32'hC0DE_1238);

        hs0 = rd_hs;
        reqs.push_back(32'h0000_2230);
        reqs.push_back(32'h0000_1230);
        reqs.push_back(32'h0000_3230);
        reqs.push_back(32'h0000_1234);
        run(400);
        chk("conflict_hs", rd_hs - hs0, 2);
        chk("conflict_rdata", last_rdata, 32'hC0DE_1234);
        reqs.push_back(32'h0000_2230);
        run(200);
        chk("evicted_hs", rd_hs - hs0, 3);

        reqs.push_back(32'hBFC0_0000);
        run(200);
        chk("unc_rd_addr", last_rd_addr, 32'h1FC0_0000);
        chk("unc_rd_type", {29'd0, last_rd_type}, 32'd2);
        chk("unc_rdata", last_rdata, 32'hDF1E_0000);
        hs0 = rd_hs;
        reqs.push_back(32'hBFC0_0000);
        run(200);
        chk("unc_again_hs", rd_hs - hs0, 1);

        bp_hold = 5;
        req_cycles = 0;
        reqs.push_back(32'h0000_4560);
        run(300);
        chk("bp_len", {31'd0, req_cycles >= 6}, 1);
        chk("bp_rdata", last_rdata, 32'hC0DE_4560);

        hs0 = rd_hs;
        rst_at2 = 1;
        reqs.push_back(32'h0000_5670);
        run(300);
        chk("rst_trig", {31'd0, rst_at2}, 0);
        stray_cnt = 3;
        repeat (4) step();
        reqs.push_back(32'h0000_5670);
        run(200);
        chk("rst_refetch_hs", rd_hs - hs0, 2);
        chk("rst_refetch_rdata", last_rdata, 32'hC0DE_5670);
        reqs.push_back(32'h0000_1230);
        run(200);
        chk("rst_cleared_hs", rd_hs - hs0, 3);

        gap_en = 1;
        for (int i = 0; i < 400; i++)
            reqs.push_back({tag_pool[$urandom_range(0, 5)],
                            idx_pool[$urandom_range(0, 3)],
                            2'($urandom_range(0, 3)), 2'b00});
        run(30000);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
